wshb_ram_slave: RTL and testbench
=================================

# wshb_ram_slave

Wishbone B4 responder (slave) backed by an on-chip single-port RAM of 32-bit words, with byte-select writes and registered-feedback incrementing bursts (cti/bte). It sits at the downstream end of a Wishbone master or interconnect, in place of the SDRAM controller, so that arbitration and video-path traffic (VGA reader, test-pattern writer) can run on-chip and be verified without external memory. Out-of-range, misaligned-burst and burst-address-mismatch accesses are terminated with `err`; `rty` is never used.

## Interface
- `ADDR_W`, 10: RAM depth is 2**ADDR_W words; byte address space covers 2**(ADDR_W+2) bytes.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cyc`  in  1  bus cycle in progress.
- `stb`  in  1  transfer strobe.
- `we`  in  1  1 = write, 0 = read.
- `adr`  in  32  byte address; `adr[1:0]` ignored.
- `sel`  in  4  byte lane enables; `sel[i]` covers `dat[8i+7:8i]`.
- `dat_ms`  in  32  write data.
- `cti`  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; other values are treated as 000.
- `bte`  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `dat_sm`  out  32  read data, valid only while `ack` is 1.
- `ack`  out  1  normal termination.
- `err`  out  1  error termination.
- `rty`  out  1  tied 0.

## Operation
- Word index is `adr[ADDR_W+1:2]`. The address is out of range if any bit of `adr[31:ADDR_W+2]` is 1.
- FSM states are IDLE, CLASSIC, BURST and ERR.
- IDLE, on `cyc&stb`:
  - Out of range: go to ERR.
  - `cti==010`: go to BURST; load the burst address counter from the word index.
  - Otherwise: go to CLASSIC.
- CLASSIC: one `ack` or `err` cycle, then return to IDLE. `ack` is always low for at least one cycle between classic transfers.
- BURST, each cycle with `cyc&stb`:
  - Compare the presented word index with the internal counter. On mismatch, terminate with `err` and go to ERR.
  - Otherwise perform the access, `ack` the beat, and advance the counter.
  - Linear counting (`bte` 00): the counter increments across the whole space. Crossing `2**ADDR_W-1` produces an out-of-range `err` on that beat.
  - Wrap-N counting: the low log2(N) bits increment modulo N; the upper bits are held.
  - A beat with `cti==111` is acked, and the FSM then goes to IDLE.
- BURST, `cyc` high with `stb` low: wait state. `ack` goes low, the counter holds, and the burst resumes when `stb` returns.
- ERR: `err` is high for one cycle, then the FSM returns to IDLE. No memory write takes place.
- Writes: for each `i` with `sel[i]` set, byte `i` is written at the edge that produces the `ack`. Bytes with `sel[i]` clear keep their old value.
- Reads: `dat_sm` = RAM word at the acked address. `dat_sm` is 0 when `ack` is 0.
- `cyc` low in any state: abort. The FSM goes to IDLE at the next edge, and `ack`/`err` go low at that edge.

## Timing
- Reset (`rst_n` low): `ack`=0, `err`=0, `rty`=0, `dat_sm`=0 and FSM=IDLE immediately, without waiting for a clock. No writes take place while `rst_n` is low. RAM contents are not reset.
- Reset asserted mid-burst: the burst is discarded. After release, the next `cyc&stb` is treated as a new cycle.
- Classic transfer: request in cycle N gives `ack` (or `err`) in N+1 and `ack` low in N+2. Throughput is 1 transfer per 2 cycles.
- Burst: first beat in cycle N gives `ack` in N+1. `ack` then stays high every cycle while `stb` is held and addresses match. Throughput is 1 beat per cycle.
- The master presents the next address and write data in the same cycle as `ack` (registered feedback).
- Read latency is 1 cycle, registered. Write commit takes 1 edge.
- `ack` and `err` are never high in the same cycle. Neither is ever asserted while `cyc` is low.

## Configuration
- `WSHB_RAM_BURST_EN` defined: BURST state, address counter, `bte` wrapping and mismatch `err` are all included.
- Not defined:
  - `cti` and `bte` are ignored; every access is classic (1 ack, then 1 idle cycle).
  - The FSM has only IDLE, CLASSIC and ERR.
  - Out-of-range `err` is still generated.

## Test plan
- Classic write then read: write `adr=0x10`, `sel=1111`, data `0xDEADBEEF`. Read `0x10` with `stb` held high. Required: `ack` in N+1, `dat_sm=0xDEADBEEF`, `ack` low in N+2.
- Byte lanes: write `0x11223344` to `0x20`, then write `0xAABBCCDD` with `sel=0101`. Required: reading `0x20` returns `0x11BB33DD`.
- Linear burst: 4 write beats to `0x100` (cti 010,010,010,111), then read them back. Required: `ack` on 4 consecutive cycles for each burst, read data matches, `ack` low after the last beat.
- Wrap-4 burst read: start word 6 (`adr=0x18`), `bte=01`. Required: words 6,7,4,5 acked in order. Presenting word 8 instead of 4 gives `err` on that beat, and `ack` stays low until the next cycle.
- Errors and abort: access `adr=0x1000` (`ADDR_W`=10). Required: `err` for 1 cycle and no write. Dropping `cyc` mid-burst gives `ack` low next edge. `rst_n` pulsed mid-burst gives all outputs 0 immediately.
- Build without `WSHB_RAM_BURST_EN`: a `cti=010` sequence on every cycle is acked only every other cycle, and data is correct.

Source files
------------

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 slave backed by a single-port 32-bit RAM, byte-lane writes, err on bad access.
// Define WSHB_RAM_BURST_EN to add registered-feedback incrementing bursts (cti/bte).
module wshb_ram_slave #(
  parameter int ADDR_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_ms_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic [31:0] dat_sm_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef WSHB_RAM_BURST_EN
  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_ERR} state_t;
`endif

  state_t              state_q;
  logic                ack_q, err_q;
  logic [31:0]         dat_q;
  logic [31:0]         mem_q [DEPTH];
  logic                req, oor, acc;
  logic [ADDR_W-1:0]   idx;

  assign req = cyc_i & stb_i;
  assign oor = |adr_i[31:ADDR_W+2];
  assign idx = adr_i[ADDR_W+1:2];

`ifdef WSHB_RAM_BURST_EN
  localparam logic [ADDR_W-1:0] ONE = 1;
  logic [ADDR_W-1:0] cnt_q, nxt;
  logic              hit;
  logic              unused_bits;

  assign unused_bits = ^adr_i[1:0];
  assign hit = (state_q == S_BURST) && (idx == cnt_q);

  // Next burst address is derived from the presented index, which equals cnt_q on a hit.
  always_comb begin
    nxt = idx + ONE;
    case (bte_i)
      2'b01:   nxt = {idx[ADDR_W-1:2], idx[1:0] + 2'd1};
      2'b10:   nxt = {idx[ADDR_W-1:3], idx[2:0] + 3'd1};
      2'b11:   nxt = {idx[ADDR_W-1:4], idx[3:0] + 4'd1};
      default: nxt = idx + ONE;
    endcase
  end

  assign acc = req & ~oor & ((state_q == S_IDLE) | hit);
`else
  logic unused_bits;
  assign unused_bits = ^{adr_i[1:0], cti_i, bte_i};
  assign acc = req & ~oor & (state_q == S_IDLE);
`endif

  always_ff @(posedge clk_i) begin
    if (acc && we_i && rst_n_i) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) mem_q[idx][8*i +: 8] <= dat_ms_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
`ifdef WSHB_RAM_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      if (!cyc_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (stb_i) begin
              if (oor) begin
                err_q   <= 1'b1;
                state_q <= S_ERR;
              end else begin
                ack_q   <= 1'b1;
                dat_q   <= we_i ? 32'd0 : mem_q[idx];
`ifdef WSHB_RAM_BURST_EN
                if (cti_i == 3'b010) begin
                  state_q <= S_BURST;
                  cnt_q   <= nxt;
                end else begin
                  state_q <= S_CLASSIC;
                end
`else
                state_q <= S_CLASSIC;
`endif
              end
            end
          end
          S_CLASSIC: state_q <= S_IDLE;
          S_ERR:     state_q <= S_IDLE;
`ifdef WSHB_RAM_BURST_EN
          S_BURST: begin
            // stb low is a wait state: counter holds, ack drops via the defaults
            if (stb_i) begin
              if (oor || !hit) begin
                err_q   <= 1'b1;
                state_q <= S_ERR;
              end else begin
                ack_q <= 1'b1;
                dat_q <= we_i ? 32'd0 : mem_q[idx];
                cnt_q <= nxt;
                if (cti_i == 3'b111) state_q <= S_IDLE;
              end
            end
          end
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dat_sm_o = dat_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign rty_o    = 1'b0;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Directed bench for wshb_ram_slave; burst vectors run only when WSHB_RAM_BURST_EN is defined.
module tb_wshb_ram_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err, rty;

  int n_vec = 0;
  int n_err = 0;

  wshb_ram_slave #(.ADDR_W(10)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .sel_i(sel), .dat_ms_i(dat_ms), .cti_i(cti), .bte_i(bte),
    .dat_sm_o(dat_sm), .ack_o(ack), .err_o(err), .rty_o(rty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [3:0] sl, input logic [31:0] d, input logic [2:0] ct,
                       input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; sel = sl; dat_ms = d; cti = ct; bte = bt;
  endtask

  task automatic bus_idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 3'b000, 2'b00);
  endtask

  task automatic wr_classic(input string tag, input logic [31:0] a, input logic [3:0] sl,
                            input logic [31:0] d);
    drive(1'b1, 1'b1, 1'b1, a, sl, d, 3'b000, 2'b00);
    tick();
    chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    bus_idle();
    tick();
    chk({tag, "_ack_low"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic rd_classic(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, a, 4'hF, 32'd0, 3'b000, 2'b00);
    tick();
    chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    chk({tag, "_dat"}, dat_sm, exp);
    bus_idle();
    tick();
    chk({tag, "_ack_low"}, {31'd0, ack}, 32'd0);
  endtask

  initial begin
    bus_idle();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rty", {31'd0, rty}, 32'd0);
    chk("rst_dat", dat_sm, 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // classic write, then read with stb held to see the forced idle cycle
    wr_classic("wr10", 32'h10, 4'hF, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0, 3'b000, 2'b00);
    tick();
    chk("rd10_ack", {31'd0, ack}, 32'd1);
    chk("rd10_dat", dat_sm, 32'hDEADBEEF);
    tick();
    chk("rd10_gap_ack", {31'd0, ack}, 32'd0);
    chk("rd10_gap_dat", dat_sm, 32'd0);
    bus_idle();
    tick();

    wr_classic("wr20a", 32'h20, 4'hF, 32'h11223344);
    wr_classic("wr20b", 32'h20, 4'h5, 32'hAABBCCDD);
    rd_classic("rd20", 32'h20, 32'h11BB33DD);

    // out of range write aliases onto word 0 and must not land
    wr_classic("wr00", 32'h0, 4'hF, 32'h12345678);
    drive(1'b1, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 3'b000, 2'b00);
    tick();
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_ack", {31'd0, ack}, 32'd0);
    bus_idle();
    tick();
    chk("oor_err_low", {31'd0, err}, 32'd0);
    rd_classic("rd00", 32'h0, 32'h12345678);

    // async reset while ack is high, with a write request pending during reset
    drive(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0, 3'b000, 2'b00);
    tick();
    chk("pre_rst_ack", {31'd0, ack}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_dat", dat_sm, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h10, 4'hF, 32'd0, 3'b000, 2'b00);
    tick();
    tick();
    chk("in_rst_ack", {31'd0, ack}, 32'd0);
    bus_idle();
    @(negedge clk) rst_n = 1'b1;
    tick();
    rd_classic("rd10_post_rst", 32'h10, 32'hDEADBEEF);

    wr_classic("wr14", 32'h14, 4'hF, 32'h55555555);

`ifndef WSHB_RAM_BURST_EN
    // burst requests degrade to classic: ack every other cycle
    drive(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0, 3'b010, 2'b00);
    tick();
    chk("nb_b0_ack", {31'd0, ack}, 32'd1);
    chk("nb_b0_dat", dat_sm, 32'hDEADBEEF);
    adr = 32'h14;
    tick();
    chk("nb_gap_ack", {31'd0, ack}, 32'd0);
    tick();
    chk("nb_b1_ack", {31'd0, ack}, 32'd1);
    chk("nb_b1_dat", dat_sm, 32'h55555555);
    bus_idle();
    tick();
    chk("nb_end_ack", {31'd0, ack}, 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hB0000000 + 32'(i),
            (i == 3) ? 3'b111 : 3'b010, 2'b00);
      tick();
      chk($sformatf("lw%0d_ack", i), {31'd0, ack}, 32'd1);
    end
    bus_idle();
    tick();
    chk("lw_end_ack", {31'd0, ack}, 32'd0);

    // linear read with one wait state after the first beat
    drive(1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'd0, 3'b010, 2'b00);
    tick();
    chk("lr0_ack", {31'd0, ack}, 32'd1);
    chk("lr0_dat", dat_sm, 32'hB0000000);
    adr = 32'h104;
    stb = 1'b0;
    tick();
    chk("lr_wait_ack", {31'd0, ack}, 32'd0);
    stb = 1'b1;
    for (int i = 1; i < 4; i++) begin
      adr = 32'h100 + 32'(4 * i);
      cti = (i == 3) ? 3'b111 : 3'b010;
      tick();
      chk($sformatf("lr%0d_ack", i), {31'd0, ack}, 32'd1);
      chk($sformatf("lr%0d_dat", i), dat_sm, 32'hB0000000 + 32'(i));
    end
    bus_idle();
    tick();
    chk("lr_end_ack", {31'd0, ack}, 32'd0);

    wr_classic("wr18", 32'h18, 4'hF, 32'h66666666);
    wr_classic("wr1c", 32'h1C, 4'hF, 32'h77777777);

    begin
      logic [31:0] wa [4];
      logic [31:0] wd [4];
      wa = '{32'h18, 32'h1C, 32'h10, 32'h14};
      wd = '{32'h66666666, 32'h77777777, 32'hDEADBEEF, 32'h55555555};
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'b1, 1'b0, wa[i], 4'hF, 32'd0, (i == 3) ? 3'b111 : 3'b010, 2'b01);
        tick();
        chk($sformatf("w4_%0d_ack", i), {31'd0, ack}, 32'd1);
        chk($sformatf("w4_%0d_dat", i), dat_sm, wd[i]);
      end
      bus_idle();
      tick();
      chk("w4_end_ack", {31'd0, ack}, 32'd0);

      // after word 7 the wrap-4 counter expects word 4; word 8 is a mismatch
      for (int i = 0; i < 2; i++) begin
        drive(1'b1, 1'b1, 1'b0, wa[i], 4'hF, 32'd0, 3'b010, 2'b01);
        tick();
        chk($sformatf("w4m_%0d_ack", i), {31'd0, ack}, 32'd1);
      end
    end
    adr = 32'h20;
    tick();
    chk("w4m_err", {31'd0, err}, 32'd1);
    chk("w4m_ack", {31'd0, ack}, 32'd0);
    bus_idle();
    tick();
    chk("w4m_err_low", {31'd0, err}, 32'd0);
    chk("w4m_ack_low", {31'd0, ack}, 32'd0);

    // abort by dropping cyc mid-burst
    drive(1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'd0, 3'b010, 2'b00);
    tick();
    chk("ab_ack", {31'd0, ack}, 32'd1);
    adr = 32'h104;
    cyc = 1'b0;
    tick();
    chk("ab_ack_low", {31'd0, ack}, 32'd0);
    chk("ab_err_low", {31'd0, err}, 32'd0);
    bus_idle();
    rd_classic("ab_rd104", 32'h104, 32'hB0000001);

    // reset mid-burst, then a fresh burst at an unrelated address
    drive(1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'd0, 3'b010, 2'b00);
    tick();
    chk("rb_ack", {31'd0, ack}, 32'd1);
    adr = 32'h104;
    #2 rst_n = 1'b0;
    #1;
    chk("rb_arst_ack", {31'd0, ack}, 32'd0);
    chk("rb_arst_dat", dat_sm, 32'd0);
    bus_idle();
    tick();
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h108, 4'hF, 32'd0, 3'b010, 2'b00);
    tick();
    chk("rb_b0_ack", {31'd0, ack}, 32'd1);
    chk("rb_b0_dat", dat_sm, 32'hB0000002);
    adr = 32'h10C;
    cti = 3'b111;
    tick();
    chk("rb_b1_ack", {31'd0, ack}, 32'd1);
    chk("rb_b1_dat", dat_sm, 32'hB0000003);
    bus_idle();
    tick();

    // linear burst running off the top of the RAM
    drive(1'b1, 1'b1, 1'b0, 32'hFFC, 4'hF, 32'd0, 3'b010, 2'b00);
    tick();
    chk("top_ack", {31'd0, ack}, 32'd1);
    adr = 32'h1000;
    tick();
    chk("top_err", {31'd0, err}, 32'd1);
    chk("top_ack_low", {31'd0, ack}, 32'd0);
    bus_idle();
    tick();
    chk("top_err_low", {31'd0, err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
